// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the BCD number-entry block.
package bcd_entry_pkg;

  typedef enum logic {ST_INT, ST_FRAC} entry_state_e;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioner: two-flop synchroniser, stability debounce and
// a single-cycle pulse on each accepted press.
module btn_conditioner #(
  parameter int unsigned DBNC_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CntW = (DBNC_CYCLES < 2) ? 1 : $clog2(DBNC_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DBNC_CYCLES - 1);

  logic            sync1_q, sync2_q, level_q, pulse_q;
  logic [CntW-1:0] cnt_q;
  logic            accept;

  assign accept = (sync2_q != level_q) && (cnt_q == CntLast);
  assign pulse  = pulse_q;

  // Reset to the "pressed" level so a button held through reset must be
  // released and pressed again before it produces a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      pulse_q <= accept && sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_entry_buffer.sv
// Button/switch BCD number entry: builds a signed fixed-point BCD value and
// hands the committed value to the datapath over a valid/ready handshake.
module bcd_entry_buffer
  import bcd_entry_pkg::*;
#(
  parameter int unsigned INT_DIGITS  = 6,
  parameter int unsigned FRAC_DIGITS = 6,
  parameter int unsigned DBNC_CYCLES = 16,
  localparam int unsigned IntW  = DIGIT_W * INT_DIGITS,
  localparam int unsigned FracW = (FRAC_DIGITS == 0) ? DIGIT_W : DIGIT_W * FRAC_DIGITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               btn_push,
  input  logic               btn_back,
  input  logic               btn_point,
  input  logic               btn_sign,
  input  logic               btn_enter,
  output logic [IntW-1:0]    out_int,
  output logic [FracW-1:0]   out_frac,
  output logic               out_neg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err
);

  localparam int unsigned IntCntW  = $clog2(INT_DIGITS + 1);
  localparam int unsigned FracCntW = (FRAC_DIGITS == 0) ? 1 : $clog2(FRAC_DIGITS + 1);

  logic p_push, p_back, p_point, p_sign, p_enter;

  btn_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_push  (.clk(clk), .rst(rst), .btn(btn_push),  .pulse(p_push));
  btn_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_back  (.clk(clk), .rst(rst), .btn(btn_back),  .pulse(p_back));
  btn_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_point (.clk(clk), .rst(rst), .btn(btn_point), .pulse(p_point));
  btn_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_sign  (.clk(clk), .rst(rst), .btn(btn_sign),  .pulse(p_sign));
  btn_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_enter (.clk(clk), .rst(rst), .btn(btn_enter), .pulse(p_enter));

  entry_state_e        state_q, state_d;
  logic [IntW-1:0]     int_q, int_d, out_int_q, out_int_d;
  logic [FracW-1:0]    frac_q, frac_d, out_frac_q, out_frac_d;
  logic [IntCntW-1:0]  int_cnt_q, int_cnt_d;
  logic [FracCntW-1:0] frac_cnt_q, frac_cnt_d;
  logic                neg_q, neg_d, out_neg_q, out_neg_d;
  logic                out_valid_q, out_valid_d, err_q, err_d;

  // Action priority: enter > back > point > sign > push.
  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    frac_d      = frac_q;
    int_cnt_d   = int_cnt_q;
    frac_cnt_d  = frac_cnt_q;
    neg_d       = neg_q;
    out_int_d   = out_int_q;
    out_frac_d  = out_frac_q;
    out_neg_d   = out_neg_q;
    out_valid_d = out_valid_q && !out_ready;
    err_d       = 1'b0;

    if (p_enter) begin
      if (out_valid_q && !out_ready) begin
        err_d = 1'b1;
      end else begin
        out_int_d   = int_q;
        out_frac_d  = frac_q;
        out_neg_d   = neg_q;
        out_valid_d = 1'b1;
        int_d       = '0;
        frac_d      = '0;
        int_cnt_d   = '0;
        frac_cnt_d  = '0;
        neg_d       = 1'b0;
        state_d     = ST_INT;
      end
    end else if (p_back) begin
      if (state_q == ST_FRAC) begin
        if (frac_cnt_q == '0) begin
          state_d = ST_INT;
        end else begin
          for (int unsigned i = 0; i < FRAC_DIGITS; i++) begin
            if (frac_cnt_q == FracCntW'(FRAC_DIGITS - i)) frac_d[DIGIT_W*i +: DIGIT_W] = '0;
          end
          frac_cnt_d = frac_cnt_q - 1'b1;
        end
      end else if (int_cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        int_d     = int_q >> DIGIT_W;
        int_cnt_d = int_cnt_q - 1'b1;
      end
    end else if (p_point) begin
      if (FRAC_DIGITS == 0 || state_q == ST_FRAC) err_d = 1'b1;
      else                                         state_d = ST_FRAC;
    end else if (p_sign) begin
      neg_d = ~neg_q;
    end else if (p_push) begin
      if (sw > BCD_MAX) begin
        err_d = 1'b1;
      end else if (state_q == ST_INT) begin
        if (int_cnt_q == IntCntW'(INT_DIGITS)) begin
          err_d = 1'b1;
        end else begin
          int_d                = int_q << DIGIT_W;
          int_d[DIGIT_W-1:0]   = sw;
          int_cnt_d            = int_cnt_q + 1'b1;
        end
      end else if (frac_cnt_q == FracCntW'(FRAC_DIGITS)) begin
        err_d = 1'b1;
      end else begin
        // Fraction is left-aligned: the n-th digit lands n nibbles below the MSB.
        for (int unsigned i = 0; i < FRAC_DIGITS; i++) begin
          if (frac_cnt_q == FracCntW'(FRAC_DIGITS - 1 - i)) frac_d[DIGIT_W*i +: DIGIT_W] = sw;
        end
        frac_cnt_d = frac_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INT;
      int_q       <= '0;
      frac_q      <= '0;
      int_cnt_q   <= '0;
      frac_cnt_q  <= '0;
      neg_q       <= 1'b0;
      out_int_q   <= '0;
      out_frac_q  <= '0;
      out_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      frac_q      <= frac_d;
      int_cnt_q   <= int_cnt_d;
      frac_cnt_q  <= frac_cnt_d;
      neg_q       <= neg_d;
      out_int_q   <= out_int_d;
      out_frac_q  <= out_frac_d;
      out_neg_q   <= out_neg_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_int   = out_int_q;
  assign out_frac  = out_frac_q;
  assign out_neg   = out_neg_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_entry_buffer.sv
// Directed bench for bcd_entry_buffer: button sequences with hand-computed results.
module tb_bcd_entry_buffer;

  localparam int BPUSH = 0, BBACK = 1, BPOINT = 2, BSIGN = 3, BENTER = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sw = 4'd0;
  logic        btn_push = 1'b0, btn_back = 1'b0, btn_point = 1'b0;
  logic        btn_sign = 1'b0, btn_enter = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] out_int, out_frac;
  logic        out_neg, out_valid, err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  bcd_entry_buffer #(
    .INT_DIGITS (6),
    .FRAC_DIGITS(6),
    .DBNC_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_push (btn_push),
    .btn_back (btn_back),
    .btn_point(btn_point),
    .btn_sign (btn_sign),
    .btn_enter(btn_enter),
    .out_int  (out_int),
    .out_frac (out_frac),
    .out_neg  (out_neg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  always @(posedge clk) if (err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      BPUSH:   btn_push  = v;
      BBACK:   btn_back  = v;
      BPOINT:  btn_point = v;
      BSIGN:   btn_sign  = v;
      default: btn_enter = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    cyc(hold);
    set_btn(b, 1'b0);
    cyc(12);
  endtask

  task automatic digit(input logic [3:0] d);
    sw = d;
    press(BPUSH, 10);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset
    cyc(3);
    chk("rst_int", out_int, 0);
    chk("rst_frac", out_frac, 0);
    chk("rst_neg", out_neg, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    cyc(5);

    // 123.45
    digit(4'd1); digit(4'd2); digit(4'd3);
    press(BPOINT, 10);
    digit(4'd4); digit(4'd5);
    press(BENTER, 10);
    chk("fix_int", out_int, 24'h000123);
    chk("fix_frac", out_frac, 24'h450000);
    chk("fix_neg", out_neg, 0);
    chk("fix_valid", out_valid, 1);
    chk("fix_err", err_cnt, exp_err);
    accept();
    chk("fix_acc_valid", out_valid, 0);

    // -7 held until ready; extra enter while pending errs and keeps output
    press(BSIGN, 10);
    digit(4'd7);
    press(BENTER, 10);
    cyc(10);
    chk("neg_neg", out_neg, 1);
    chk("neg_int", out_int, 24'h000007);
    chk("neg_valid", out_valid, 1);
    press(BENTER, 10);
    exp_err++;
    chk("neg_busy_err", err_cnt, exp_err);
    chk("neg_hold_int", out_int, 24'h000007);
    chk("neg_hold_neg", out_neg, 1);
    accept();
    chk("neg_acc_valid", out_valid, 0);

    // Bounce shorter than the debounce window, then one long clean press
    sw = 4'd5;
    btn_push = 1'b1; cyc(3); btn_push = 1'b0; cyc(3);
    btn_push = 1'b1; cyc(2); btn_push = 1'b0; cyc(12);
    press(BPUSH, 50);
    press(BENTER, 10);
    chk("dbnc_int", out_int, 24'h000005);
    chk("dbnc_neg", out_neg, 0);
    accept();

    // Integer overflow and invalid digit
    for (int i = 0; i < 6; i++) digit(4'd9);
    chk("ovf_no_err", err_cnt, exp_err);
    digit(4'd9);
    exp_err++;
    chk("ovf_err", err_cnt, exp_err);
    digit(4'hA);
    exp_err++;
    chk("bad_digit_err", err_cnt, exp_err);
    press(BENTER, 10);
    chk("ovf_int", out_int, 24'h999999);
    chk("ovf_frac", out_frac, 0);
    accept();

    // Backspace through fraction into integer part
    digit(4'd1); digit(4'd2);
    press(BPOINT, 10);
    digit(4'd3);
    press(BPOINT, 10);
    exp_err++;
    chk("point_twice_err", err_cnt, exp_err);
    press(BBACK, 10); press(BBACK, 10); press(BBACK, 10);
    chk("back_no_err", err_cnt, exp_err);
    digit(4'd4);
    press(BENTER, 10);
    chk("back_int", out_int, 24'h000014);
    chk("back_frac", out_frac, 0);
    accept();
    press(BBACK, 10);
    exp_err++;
    chk("back_empty_err", err_cnt, exp_err);

    // Reset mid-entry with a pending output and a button held through reset
    digit(4'd8);
    press(BENTER, 10);
    chk("pend_valid", out_valid, 1);
    press(BPOINT, 10);
    sw = 4'd3;
    btn_push = 1'b1;
    cyc(10);
    rst = 1'b1;
    cyc(1);
    chk("mrst_int", out_int, 0);
    chk("mrst_frac", out_frac, 0);
    chk("mrst_neg", out_neg, 0);
    chk("mrst_valid", out_valid, 0);
    cyc(1);
    rst = 1'b0;
    cyc(20);
    btn_push = 1'b0;
    cyc(12);
    digit(4'd6);
    press(BENTER, 10);
    chk("post_rst_int", out_int, 24'h000006);
    chk("post_rst_frac", out_frac, 0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_err", err_cnt, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
